// File: rtl/modulo_condicionador_botoes.sv
// Operator-input conditioning: per-channel 2-flop synchronizer, debounce, press/release
// pulses and optional auto-repeat for held keys.
module modulo_condicionador_botoes #(
   parameter int               N_BTN         = 4,
   parameter int               DB_CYCLES     = 4,
   parameter int               HOLD_CYCLES   = 16,
   parameter int               REPEAT_CYCLES = 4,
   parameter logic [N_BTN-1:0] ACTIVE_LOW    = 4'b1111,
   parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b0010
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] raw_in,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   // "release" is a reserved word in SystemVerilog, hence the longer name
   output logic [N_BTN-1:0] release_pulse
);

   localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HOLD = 2'd1,
      REPEATING = 2'd2
   } rep_state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic       sync1;
      logic       sync2;
      logic [7:0] db_cnt;
      logic [7:0] db_next;
      logic [15:0] rep_cnt;
      logic [15:0] rep_next;
      rep_state_t state;
      rep_state_t state_next;
      logic       s;
      logic       level_next;
      logic       edge_press;
      logic       edge_release;
      logic       rep_pulse;

      always_comb begin
         s            = sync2 ^ ACTIVE_LOW[i];
         db_next      = db_cnt;
         level_next   = level[i];
         edge_press   = 1'b0;
         edge_release = 1'b0;
         if (s == level[i]) begin
            db_next = 8'd0;
         end else if (db_cnt == DB_LAST) begin
            level_next   = s;
            db_next      = 8'd0;
            edge_press   = s;
            edge_release = ~s;
         end else begin
            db_next = db_cnt + 8'd1;
         end
      end

      // Release wins over a repeat that falls due on the same edge.
      always_comb begin
         state_next = state;
         rep_next   = rep_cnt;
         rep_pulse  = 1'b0;
         if (REPEAT_MASK[i]) begin
            case (state)
               IDLE: begin
                  if (edge_press) begin
                     state_next = WAIT_HOLD;
                     rep_next   = 16'd0;
                  end
               end
               WAIT_HOLD: begin
                  if (edge_release) begin
                     state_next = IDLE;
                     rep_next   = 16'd0;
                  end else if (rep_cnt == HOLD_LAST) begin
                     state_next = REPEATING;
                     rep_next   = 16'd0;
                     rep_pulse  = 1'b1;
                  end else begin
                     rep_next = rep_cnt + 16'd1;
                  end
               end
               REPEATING: begin
                  if (edge_release) begin
                     state_next = IDLE;
                     rep_next   = 16'd0;
                  end else if (rep_cnt == REP_LAST) begin
                     rep_next  = 16'd0;
                     rep_pulse = 1'b1;
                  end else begin
                     rep_next = rep_cnt + 16'd1;
                  end
               end
               default: begin
                  state_next = IDLE;
                  rep_next   = 16'd0;
               end
            endcase
         end
      end

      // Synchronizers reset to the released level so no spurious press follows reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            sync1            <= ACTIVE_LOW[i];
            sync2            <= ACTIVE_LOW[i];
            db_cnt           <= 8'd0;
            rep_cnt          <= 16'd0;
            state            <= IDLE;
            level[i]         <= 1'b0;
            press[i]         <= 1'b0;
            release_pulse[i] <= 1'b0;
         end else begin
            sync1            <= raw_in[i];
            sync2            <= sync1;
            db_cnt           <= db_next;
            rep_cnt          <= rep_next;
            state            <= state_next;
            level[i]         <= level_next;
            press[i]         <= edge_press | rep_pulse;
            release_pulse[i] <= edge_release;
         end
      end
   end

endmodule

// File: tb/tb_modulo_condicionador_botoes.sv
// Directed bench for modulo_condicionador_botoes: logs pulse edge numbers per channel
// and compares them against hand-computed edge numbers.
module tb_modulo_condicionador_botoes;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] raw_in;
   logic [N-1:0] level;
   logic [N-1:0] press;
   logic [N-1:0] release_pulse;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int press_t[N][$];
   int rel_t[N][$];

   modulo_condicionador_botoes #(
      .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(4),
      .ACTIVE_LOW(4'b1111), .REPEAT_MASK(4'b0010)
   ) dut (
      .clk(clk),
      .reset(reset),
      .raw_in(raw_in),
      .level(level),
      .press(press),
      .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Each pulse is logged with the number of the edge that produced it.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (press[i]) press_t[i].push_back(cyc);
         if (release_pulse[i]) rel_t[i].push_back(cyc);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      for (int i = 0; i < N; i++) begin
         press_t[i].delete();
         rel_t[i].delete();
      end
   endtask

   function automatic int pget(input int ch, input int k);
      return (press_t[ch].size() > k) ? press_t[ch][k] : -1;
   endfunction

   function automatic int rget(input int ch, input int k);
      return (rel_t[ch].size() > k) ? rel_t[ch][k] : -1;
   endfunction

   function automatic int total_pulses();
      int t = 0;
      for (int i = 0; i < N; i++) t += press_t[i].size() + rel_t[i].size();
      return t;
   endfunction

   int c;
   int r;
   int offs[7] = '{0, 16, 20, 24, 28, 32, 36};

   initial begin
      reset  = 1'b1;
      raw_in = 4'b1111;
      tick(3);
      chk("reset_level", int'(level), 0);
      chk("reset_press", int'(press), 0);
      chk("reset_release", int'(release_pulse), 0);
      reset = 1'b0;
      clear_logs();
      tick(50);
      chk("quiet_pulses", total_pulses(), 0);
      chk("quiet_level", int'(level), 0);

      // Clean press and release on ch0
      clear_logs();
      c = cyc; raw_in[0] = 1'b0;
      tick(20);
      chk("ch0_press_cnt", press_t[0].size(), 1);
      chk("ch0_press_time", pget(0, 0), c + 6);
      chk("ch0_level_hi", int'(level[0]), 1);
      c = cyc; raw_in[0] = 1'b1;
      tick(20);
      chk("ch0_rel_cnt", rel_t[0].size(), 1);
      chk("ch0_rel_time", rget(0, 0), c + 6);
      chk("ch0_level_lo", int'(level[0]), 0);
      chk("ch0_press_cnt2", press_t[0].size(), 1);

      // Bounce on ch0: 3 low, 1 high, 3 low, 1 high, then steady low
      clear_logs();
      c = cyc; raw_in[0] = 1'b0;
      tick(3); raw_in[0] = 1'b1;
      tick(1); raw_in[0] = 1'b0;
      tick(3); raw_in[0] = 1'b1;
      tick(1); raw_in[0] = 1'b0;
      tick(20);
      chk("bounce_press_cnt", press_t[0].size(), 1);
      chk("bounce_press_time", pget(0, 0), c + 14);
      chk("bounce_rel_cnt", rel_t[0].size(), 0);
      raw_in[0] = 1'b1;
      tick(20);

      // Held ch1 with auto-repeat; release lands on the edge a repeat would fire
      clear_logs();
      c = cyc; raw_in[1] = 1'b0;
      tick(40); raw_in[1] = 1'b1;
      tick(30);
      chk("ch1_press_cnt", press_t[1].size(), 7);
      for (int k = 0; k < 7; k++)
         chk($sformatf("ch1_press_t%0d", k), pget(1, k), c + 6 + offs[k]);
      chk("ch1_rel_cnt", rel_t[1].size(), 1);
      chk("ch1_rel_time", rget(1, 0), c + 46);

      // Held ch2 without auto-repeat, together with a coincident ch3 press
      clear_logs();
      c = cyc; raw_in[2] = 1'b0; raw_in[3] = 1'b0;
      tick(10); raw_in[3] = 1'b1;
      tick(30); raw_in[2] = 1'b1;
      tick(30);
      chk("ch2_press_cnt", press_t[2].size(), 1);
      chk("ch2_press_time", pget(2, 0), c + 6);
      chk("ch2_rel_cnt", rel_t[2].size(), 1);
      chk("ch2_rel_time", rget(2, 0), c + 46);
      chk("ch3_press_time", pget(3, 0), c + 6);
      chk("ch3_rel_time", rget(3, 0), c + 16);
      chk("ch3_press_cnt", press_t[3].size(), 1);

      // One-cycle reset while ch1 is repeating
      clear_logs();
      c = cyc; raw_in[1] = 1'b0;
      tick(24);
      reset = 1'b1;
      tick(1);
      r = cyc;
      chk("rst_mid_level", int'(level), 0);
      chk("rst_mid_press", int'(press), 0);
      chk("rst_mid_release", int'(release_pulse), 0);
      reset = 1'b0;
      tick(20); raw_in[1] = 1'b1;
      tick(30);
      chk("rst_press_cnt", press_t[1].size(), 4);
      chk("rst_press_t0", pget(1, 0), c + 6);
      chk("rst_press_t1", pget(1, 1), c + 22);
      chk("rst_press_t2", pget(1, 2), r + 6);
      chk("rst_press_t3", pget(1, 3), r + 22);
      chk("rst_rel_cnt", rel_t[1].size(), 1);
      chk("rst_rel_time", rget(1, 0), r + 26);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
